// File: rtl/fpu_bus_master_pkg.sv
// Shared types and register map for the FPU byte-wide register interface
// and the bus master that drives it.
package pa_fpu;

  typedef enum logic [7:0] {
    FPU_OP_NOP = 8'h00,
    FPU_OP_ADD = 8'h01,
    FPU_OP_SUB = 8'h02,
    FPU_OP_MUL = 8'h03,
    FPU_OP_DIV = 8'h04
  } e_fpu_operation;

  localparam logic [3:0] FPU_ADDR_OPA0 = 4'h0;
  localparam logic [3:0] FPU_ADDR_OPB0 = 4'h4;
  localparam logic [3:0] FPU_ADDR_CMD  = 4'h8;
  localparam logic [3:0] FPU_ADDR_RES0 = 4'h9;
  localparam logic [3:0] FPU_ADDR_RES3 = 4'hC;

  typedef enum logic [3:0] {
    BM_IDLE, BM_WR_A, BM_WR_B, BM_WR_CMD, BM_WAIT_END,
    BM_RD_RES, BM_ACK, BM_WAIT_CLR, BM_RESP
  } e_fpu_bm_state;

  typedef enum logic [2:0] {
    BC_IDLE, BC_SETUP, BC_STROBE, BC_HOLD, BC_GAP
  } e_fpu_bc_phase;

endpackage

// File: rtl/fpu_bus_master_cycle.sv
// One FPU register access: SETUP / STROBE / HOLD of PHASE_CYC clocks each,
// then a single GAP clock with cs high. done_o marks the GAP clock.
module fpu_bus_cycle
  import pa_fpu::*;
#(
  parameter int PHASE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       is_read_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] bus_rdata_i,
  output logic       cs_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic [3:0] addr_o,
  output logic [7:0] wdata_o,
  output logic [7:0] rdata_o,
  output logic       done_o
);

  localparam logic [3:0] PH_LAST = 4'(PHASE_CYC - 1);

  e_fpu_bc_phase phase_q;
  logic [3:0]    cnt_q;
  logic          read_q;
  logic          cs_q, rd_q, wr_q;
  logic [3:0]    addr_q;
  logic [7:0]    wdata_q, rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= BC_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (phase_q)
        BC_IDLE, BC_GAP: begin
          cs_q <= 1'b1;
          if (start_i) begin
            phase_q <= BC_SETUP;
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            read_q  <= is_read_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
          end else begin
            phase_q <= BC_IDLE;
          end
        end
        BC_SETUP: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == PH_LAST) begin
            phase_q <= BC_STROBE;
            cnt_q   <= '0;
            rd_q    <= ~read_q;
            wr_q    <= read_q;
          end
        end
        BC_STROBE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == PH_LAST) begin
            phase_q <= BC_HOLD;
            cnt_q   <= '0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            // Last strobe clock: the FPU has had the full strobe to drive data.
            if (read_q) rdata_q <= bus_rdata_i;
          end
        end
        BC_HOLD: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == PH_LAST) begin
            phase_q <= BC_GAP;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
          end
        end
        default: phase_q <= BC_IDLE;
      endcase
    end
  end

  assign cs_o    = cs_q;
  assign rd_o    = rd_q;
  assign wr_o    = wr_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign done_o  = (phase_q == BC_GAP);

endmodule

// File: rtl/fpu_bus_master.sv
// Host-side command sequencer for the byte-wide FPU register port.
// Optional FPU_BM_CMD_END_SYNC_EN: 2-flop synchronisers on fpu_cmd_end / fpu_busy.
module fpu_bus_master
  import pa_fpu::*;
#(
  parameter int PHASE_CYC   = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  input  logic [7:0]  cmd_opcode,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [7:0]  fpu_data_wr,
  input  logic [7:0]  fpu_data_rd,
  output logic [3:0]  fpu_addr,
  output logic        fpu_cs,
  output logic        fpu_rd,
  output logic        fpu_wr,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  e_fpu_bm_state    state_q;
  logic             cmd_ready_q, res_valid_q, res_err_q, end_ack_q;
  logic [31:0]      res_data_q, op_a_q, op_b_q;
  logic [7:0]       opcode_q;
  logic [TMO_W-1:0] tmo_q;
  logic             cmd_end_s, busy_s, accept;
  logic             bc_start_d, bc_read_d, bc_done;
  logic [3:0]       bc_addr_d, bc_addr;
  logic [7:0]       bc_wdata_d, bc_rdata;
  logic [1:0]       rb;

`ifdef FPU_BM_CMD_END_SYNC_EN
  logic [1:0] end_sync_q, busy_sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      end_sync_q  <= '0;
      busy_sync_q <= '0;
    end else begin
      end_sync_q  <= {end_sync_q[0], fpu_cmd_end};
      busy_sync_q <= {busy_sync_q[0], fpu_busy};
    end
  end
  assign cmd_end_s = end_sync_q[1];
  assign busy_s    = busy_sync_q[1];
`else
  assign cmd_end_s = fpu_cmd_end;
  assign busy_s    = fpu_busy;
`endif

  function automatic logic [7:0] wr_byte(input logic [3:0] i, input logic [31:0] a,
                                         input logic [31:0] b, input logic [7:0] op);
    case (i[3:2])
      2'b00:   return a[{i[1:0], 3'b000} +: 8];
      2'b01:   return b[{i[1:0], 3'b000} +: 8];
      default: return (i == FPU_ADDR_CMD) ? op : 8'h00;
    endcase
  endfunction

  assign accept = (state_q == BM_IDLE) && cmd_ready_q && cmd_valid;
  assign rb     = 2'(bc_addr - FPU_ADDR_RES0);

  // Next bus access is launched during the GAP clock of the previous one,
  // so consecutive accesses run back to back at 3*PHASE_CYC+1 clocks each.
  always_comb begin
    bc_start_d = 1'b0;
    bc_read_d  = 1'b0;
    bc_addr_d  = bc_addr + 4'd1;
    bc_wdata_d = wr_byte(bc_addr_d, op_a_q, op_b_q, opcode_q);
    case (state_q)
      BM_IDLE: if (accept) begin
        bc_start_d = 1'b1;
        bc_addr_d  = FPU_ADDR_OPA0;
        bc_wdata_d = cmd_op_a[7:0];
      end
      BM_WR_A, BM_WR_B, BM_WR_CMD: bc_start_d = bc_done && (bc_addr != FPU_ADDR_CMD);
      BM_WAIT_END: if (cmd_end_s) begin
        bc_start_d = 1'b1;
        bc_read_d  = 1'b1;
        bc_addr_d  = FPU_ADDR_RES0;
        bc_wdata_d = 8'h00;
      end
      BM_RD_RES: begin
        bc_read_d  = 1'b1;
        bc_wdata_d = 8'h00;
        bc_start_d = bc_done && (bc_addr != FPU_ADDR_RES3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BM_IDLE;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      end_ack_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      case (state_q)
        BM_IDLE: begin
          cmd_ready_q <= ~busy_s;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            op_a_q      <= cmd_op_a;
            op_b_q      <= cmd_op_b;
            opcode_q    <= cmd_opcode;
            state_q     <= BM_WR_A;
          end
        end
        BM_WR_A:   if (bc_done && bc_addr == FPU_ADDR_OPB0 - 4'd1) state_q <= BM_WR_B;
        BM_WR_B:   if (bc_done && bc_addr == FPU_ADDR_CMD - 4'd1)  state_q <= BM_WR_CMD;
        BM_WR_CMD: if (bc_done) begin
          state_q <= BM_WAIT_END;
          tmo_q   <= TMO_LOAD;
        end
        BM_WAIT_END: begin
          if (cmd_end_s) begin
            state_q <= BM_RD_RES;
          end else if (tmo_q == '0) begin
            state_q     <= BM_RESP;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        BM_RD_RES: if (bc_done) begin
          res_data_q[{rb, 3'b000} +: 8] <= bc_rdata;
          if (bc_addr == FPU_ADDR_RES3) begin
            state_q   <= BM_ACK;
            end_ack_q <= 1'b1;
          end
        end
        BM_ACK: begin
          state_q <= BM_WAIT_CLR;
          tmo_q   <= TMO_LOAD;
        end
        BM_WAIT_CLR: begin
          if (!cmd_end_s || tmo_q == '0) begin
            end_ack_q   <= 1'b0;
            state_q     <= BM_RESP;
            res_valid_q <= 1'b1;
            res_err_q   <= cmd_end_s;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        BM_RESP: if (res_ready) begin
          res_valid_q <= 1'b0;
          res_err_q   <= 1'b0;
          cmd_ready_q <= ~busy_s;
          state_q     <= BM_IDLE;
        end
        default: state_q <= BM_IDLE;
      endcase
    end
  end

  fpu_bus_cycle #(.PHASE_CYC(PHASE_CYC)) u_cycle (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (bc_start_d),
    .is_read_i   (bc_read_d),
    .addr_i      (bc_addr_d),
    .wdata_i     (bc_wdata_d),
    .bus_rdata_i (fpu_data_rd),
    .cs_o        (fpu_cs),
    .rd_o        (fpu_rd),
    .wr_o        (fpu_wr),
    .addr_o      (bc_addr),
    .wdata_o     (fpu_data_wr),
    .rdata_o     (bc_rdata),
    .done_o      (bc_done)
  );

  assign fpu_addr    = bc_addr;
  assign cmd_ready   = cmd_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign fpu_end_ack = end_ack_q;

endmodule

// File: doc/fpu_bus_master.md
Name: fpu_bus_master

Overview:
- Upstream command sequencer for the byte-wide FPU register interface.
- Accepts one 32-bit operand pair plus opcode per transaction through a valid/ready handshake.
- Drives the FPU's 8-bit chip-select/read/write port: writes A (addr 0-3), B (addr 4-7) and opcode (addr 8), waits for cmd_end, reads the result (addr 9-C), then handshakes end_ack.
- Returns the 32-bit result and an error flag to the host through a valid/ready handshake.

Parameters:
- PHASE_CYC, 1: clocks per bus phase (setup, strobe, hold); legal range 1-15.
- TIMEOUT_CYC, 4096: maximum clocks spent waiting on each cmd_end edge before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  block idle; command accepted when cmd_valid&cmd_ready
- cmd_op_a  in  32  operand A
- cmd_op_b  in  32  operand B
- cmd_opcode  in  8  pa_fpu::e_fpu_operation value
- res_valid  out  1  result available
- res_ready  in  1  host takes result
- res_data  out  32  FPU result, little-endian byte assembly
- res_err  out  1  timeout abort
- fpu_data_wr  out  8  to FPU databus_in
- fpu_data_rd  in  8  from FPU databus_out
- fpu_addr  out  4  FPU register address
- fpu_cs  out  1  active-low chip select
- fpu_rd  out  1  active-low read strobe
- fpu_wr  out  1  active-low write strobe
- fpu_end_ack  out  1  end acknowledge, active high
- fpu_cmd_end  in  1  FPU command-complete flag
- fpu_busy  in  1  FPU busy; sampled only in IDLE

Behaviour:
- Reset values (all registered outputs):
  - cmd_ready=0 for the reset cycle, then 1
  - res_valid=0, res_data=0, res_err=0
  - fpu_cs=1, fpu_rd=1, fpu_wr=1
  - fpu_end_ack=0, fpu_addr=0, fpu_data_wr=0
- Accept: cmd_ready=1 only in IDLE with fpu_busy=0. Operands and opcode are latched on the accepting edge.
- Bus transaction, each phase PHASE_CYC clocks:
  - SETUP: cs=0, addr and data valid
  - STROBE: wr=0 or rd=0
  - HOLD: strobe=1, cs=0
  - then one GAP cycle with cs=1
  - Total per transaction: 3*PHASE_CYC+1 clocks.
- Read sampling: fpu_data_rd is sampled on the last clock of STROBE.
- States and transitions:
  - IDLE -> WR_A(bytes 0..3) -> WR_B(4..7) -> WR_CMD(8) -> WAIT_END -> RD_RES(9..C) -> ACK -> WAIT_CLR -> RESP -> IDLE
  - WAIT_END: wait for fpu_cmd_end=1.
  - ACK: assert fpu_end_ack=1.
  - WAIT_CLR: hold end_ack until fpu_cmd_end=0, then drop end_ack.
  - RESP: assert res_valid; leave when res_ready=1.
- Latency, PHASE_CYC=1: 36 clocks from acceptance to WAIT_END entry; 16 clocks of reads.
- Byte order: byte n goes to addr base+n carrying bits [8n+7:8n]. Addr C holds res_data[31:24].
- Timeout:
  - One counter, reloaded on entry to WAIT_END and to WAIT_CLR.
  - Expiry in WAIT_END: go to RESP with res_err=1, res_data=0; no reads, no end_ack.
  - Expiry in WAIT_CLR: drop end_ack and go to RESP with res_err=1; read data is kept.
- Backpressure: res_valid, res_data and res_err are held stable until res_ready. No new command is accepted while in RESP.
- Early cmd_end: fpu_cmd_end=1 already high before WAIT_END is honoured immediately on WAIT_END entry; no edge is required.
- cmd_valid outside IDLE: ignored. Inputs are not re-latched.
- Reset mid-operation: the next edge with rst_n=0 returns to IDLE and releases all strobes. The FPU is not re-synchronised; the host must reset the FPU too.
- Invariants:
  - fpu_rd=0 and fpu_wr=0 never occur together.
  - Strobes are only low while fpu_cs=0.

Optional Feature:
- Macro: FPU_BM_CMD_END_SYNC_EN.
- Defined: fpu_cmd_end and fpu_busy pass through a 2-flop synchroniser before use. WAIT_END and WAIT_CLR each see +2 clocks of response latency. The timeout counts synchronised cycles.
- Undefined: both signals are used directly, with zero added latency.

Decomposition:
- Package pa_fpu, extended with:
  - e_fpu_operation, unchanged
  - address localparams FPU_ADDR_OPA0=4'h0, FPU_ADDR_OPB0=4'h4, FPU_ADDR_CMD=4'h8, FPU_ADDR_RES0=4'h9
  - e_fpu_bm_state enum
- Sub-module fpu_bus_cycle: executes one read or write transaction (SETUP/STROBE/HOLD/GAP timing).
  - Inputs: start, is_read, addr, wdata.
  - Outputs: cs, rd, wr, rdata, done.
  - The top-level FSM sequences 13 of these per command.

Test Plan:
- A=43a9ab64, B=c479fff0, opcode=add; behavioural FPU raises cmd_end 50 clocks after the opcode write and returns c4252a3d -> bus writes 64,ab,a9,43 to addr 0-3 and f0,ff,79,c4 to addr 4-7; opcode at addr 8; res_data=c4252a3d, res_err=0, end_ack pulse observed.
- PHASE_CYC=3 -> every strobe low for exactly 3 clocks; cs high for exactly 1 clock between transactions; rd/wr never low together.
- FPU never raises cmd_end, TIMEOUT_CYC=64 -> res_valid 64 clocks after WAIT_END entry; res_err=1, res_data=0; no rd strobe, end_ack stays 0.
- res_ready held low 20 clocks after res_valid -> outputs stable; cmd_valid=1 meanwhile is not accepted; accepted one clock after RESP exits.
- rst_n low during RD_RES byte 2 -> next edge cs/rd/wr=1, end_ack=0, res_valid=0; cmd_ready=1 once rst_n rises and fpu_busy=0.
- With FPU_BM_CMD_END_SYNC_EN, repeat test 1 -> identical bus data and result; the first RD_RES strobe occurs 2 clocks later than without the macro.
